// File: rtl/sha256_digest_checker.sv
// SHA-256 digest checker: feed-forward add of the chaining midstate onto the
// final round state, leading-zero difficulty test on digest word 7, and a
// small hit FIFO drained through a valid/ready port.
module sha256_digest_checker #(
  parameter int ZERO_BITS  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [255:0] rx_state,
  input  logic [255:0] mid_state,
  input  logic         nonce_load,
  input  logic [31:0]  nonce_start,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_nonce,
  output logic [255:0] out_digest,
  output logic [31:0]  hash_count,
  output logic         drop_flag
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]  nonce_cnt;
  logic [31:0]  beat_tag;
  logic [255:0] add_sum;

  logic         s1_v;
  logic [255:0] s1_dig;
  logic [31:0]  s1_nonce;

  logic         s2_hit;
  logic [255:0] s2_dig;
  logic [31:0]  s2_nonce;

  logic [287:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          pop;
  logic          push_ok;
  logic          push_drop;

  // A load coinciding with a beat tags that beat with the new start value.
  assign beat_tag = nonce_load ? nonce_start : nonce_cnt;

  // Per-word modular add; carries never cross 32-bit word boundaries.
  for (genvar i = 0; i < 8; i++) begin : g_ff_add
    assign add_sum[32*i +: 32] = rx_state[32*i +: 32] + mid_state[32*i +: 32];
  end

  // Nonce counter: advances once per beat, reloadable at any time.
  always_ff @(posedge clk) begin
    if (rst) begin
      nonce_cnt <= '0;
    end else if (in_valid) begin
      nonce_cnt <= beat_tag + 32'd1;
    end else if (nonce_load) begin
      nonce_cnt <= nonce_start;
    end
  end

  // Stage 1: capture the feed-forward sum, the nonce tag and count the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v       <= 1'b0;
      s1_dig     <= '0;
      s1_nonce   <= '0;
      hash_count <= '0;
    end else begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_dig     <= add_sum;
        s1_nonce   <= beat_tag;
        hash_count <= hash_count + 32'd1;
      end
    end
  end

  // Stage 2: difficulty test on the top ZERO_BITS of digest word 7.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_hit   <= 1'b0;
      s2_dig   <= '0;
      s2_nonce <= '0;
    end else begin
      s2_hit   <= s1_v && (s1_dig[255 -: ZERO_BITS] == '0);
      s2_dig   <= s1_dig;
      s2_nonce <= s1_nonce;
    end
  end

  // FIFO control: a full FIFO still accepts a push when the head pops that cycle.
  always_comb begin
    pop        = out_valid && out_ready;
    push_ok    = s2_hit && ((count != DEPTH_C) || pop);
    push_drop  = s2_hit && (count == DEPTH_C) && !pop;
    rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
    count_nxt  = count;
    if (push_ok && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!push_ok && pop) begin
      count_nxt = count - CW'(1);
    end
  end

  assign out_valid = (count != '0);

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      drop_flag <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (push_drop) begin
        drop_flag <= 1'b1;
      end
    end
  end

  // Entry storage; contents are only visible through the head registers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= {s2_nonce, s2_dig};
    end
  end

  // Head registers: load whichever entry will be at the head next cycle, taking
  // the incoming hit directly when it lands in the head slot; hold when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_nonce  <= '0;
      out_digest <= '0;
    end else if (count_nxt != '0) begin
      if (push_ok && (rd_ptr_nxt == wr_ptr)) begin
        out_nonce  <= s2_nonce;
        out_digest <= s2_dig;
      end else begin
        {out_nonce, out_digest} <= fifo_mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: tb/tb_sha256_digest_checker.sv
// Directed bench for sha256_digest_checker (ZERO_BITS=1, FIFO_DEPTH=4).
module tb_sha256_digest_checker;

  localparam int ZB = 1;
  localparam int FD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [255:0] rx_state;
  logic [255:0] mid_state;
  logic         nonce_load;
  logic [31:0]  nonce_start;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_nonce;
  logic [255:0] out_digest;
  logic [31:0]  hash_count;
  logic         drop_flag;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]  got_nonce [$];
  logic [255:0] got_dig   [$];

  logic [31:0]  kd [8];
  logic [31:0]  kh [8];
  logic [31:0]  kr [8];
  logic [255:0] exp_dig [8];

  sha256_digest_checker #(.ZERO_BITS(ZB), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .rx_state    (rx_state),
    .mid_state   (mid_state),
    .nonce_load  (nonce_load),
    .nonce_start (nonce_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_nonce   (out_nonce),
    .out_digest  (out_digest),
    .hash_count  (hash_count),
    .drop_flag   (drop_flag)
  );

  always #5 clk = ~clk;

  // Record every accepted head on the falling edge, between driving and popping.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_nonce.push_back(out_nonce);
      got_dig.push_back(out_digest);
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack8(input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7);
    return {w7, w6, w5, w4, w3, w2, w1, w0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    nonce_load = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    got_nonce.delete();
    got_dig.delete();
  endtask

  task automatic load_nonce(input logic [31:0] v);
    nonce_load  = 1'b1;
    nonce_start = v;
    tick();
    nonce_load = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    rx_state    = '0;
    mid_state   = '0;
    nonce_load  = 1'b0;
    nonce_start = '0;
    out_ready   = 1'b0;

    // ---- 1: basic flow, latency, ordering ----
    do_reset();
    chk("rst_out_valid",  out_valid,  0);
    chk("rst_out_nonce",  out_nonce,  0);
    chk("rst_out_digest", out_digest, 0);
    chk("rst_hash_count", hash_count, 0);
    chk("rst_drop_flag",  drop_flag,  0);
    out_ready = 1'b1;
    load_nonce(32'h100);
    mid_state = '0;
    for (int i = 0; i < 5; i++) begin
      in_valid    = 1'b1;
      rx_state    = pack8(32'h1000 + i, 32'h2000 + i, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h0);
      exp_dig[i]  = rx_state;
      tick();
      if (i < 2)  chk("t1_ov_early", out_valid, 0);
      if (i == 2) chk("t1_ov_t3",    out_valid, 1);
    end
    idle(8);
    chk("t1_count", got_nonce.size(), 5);
    for (int i = 0; i < 5 && i < got_nonce.size(); i++) begin
      chk("t1_nonce",  got_nonce[i], 32'h100 + i);
      chk("t1_digest", got_dig[i],   exp_dig[i]);
    end
    chk("t1_hash_count", hash_count, 5);
    chk("t1_ov_drained", out_valid,  0);

    // ---- 2: known-answer feed-forward ("abc") ----
    kd = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
           32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    kh = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int i = 0; i < 8; i++) kr[i] = kd[i] - kh[i];
    do_reset();
    out_ready   = 1'b1;
    // Genuine digest has word7 MSB set: a miss, tagged via load-with-beat.
    nonce_load  = 1'b1;
    nonce_start = 32'habcd0000;
    in_valid    = 1'b1;
    rx_state    = pack8(kr[0], kr[1], kr[2], kr[3], kr[4], kr[5], kr[6], kr[7]);
    mid_state   = pack8(kh[0], kh[1], kh[2], kh[3], kh[4], kh[5], kh[6], kh[7]);
    tick();
    nonce_load  = 1'b0;
    // Same beat with word7 midstate flipped at bit 31 so the sum clears the MSB.
    mid_state   = pack8(kh[0], kh[1], kh[2], kh[3], kh[4], kh[5], kh[6], kh[7] ^ 32'h80000000);
    tick();
    idle(6);
    chk("t2_count", got_nonce.size(), 1);
    if (got_nonce.size() > 0) begin
      chk("t2_nonce",  got_nonce[0], 32'habcd0001);
      chk("t2_digest", got_dig[0],
          {32'h720015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
           32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf});
    end
    chk("t2_hash_count", hash_count, 2);

    // ---- 3: overflow with out_ready low ----
    do_reset();
    out_ready = 1'b0;
    mid_state = '0;
    load_nonce(32'h200);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      rx_state = pack8(32'h10 + i, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    idle(4);
    chk("t3_drop_flag", drop_flag, 1);
    chk("t3_ov_full",   out_valid, 1);
    chk("t3_head",      out_nonce, 32'h200);
    idle(3);
    chk("t3_head_hold", out_nonce,  32'h200);
    chk("t3_dig_hold",  out_digest, pack8(32'h10, 0, 0, 0, 0, 0, 0, 0));
    out_ready = 1'b1;
    idle(8);
    chk("t3_pops", got_nonce.size(), 4);
    for (int i = 0; i < 4 && i < got_nonce.size(); i++)
      chk("t3_nonce", got_nonce[i], 32'h200 + i);
    chk("t3_ov_fell",   out_valid, 0);
    chk("t3_drop_kept", drop_flag, 1);
    chk("t3_last_held", out_nonce, 32'h203);

    // ---- 4: push and pop in the same cycle while full ----
    do_reset();
    out_ready = 1'b0;
    load_nonce(32'h300);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      rx_state = pack8(32'h20 + i, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    in_valid  = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_no_drop", drop_flag, 0);
    chk("t4_head",    out_nonce, 32'h301);
    chk("t4_one_pop", got_nonce.size(), 1);
    idle(2);
    out_ready = 1'b1;
    idle(8);
    chk("t4_total", got_nonce.size(), 5);
    for (int i = 0; i < 5 && i < got_nonce.size(); i++)
      chk("t4_nonce", got_nonce[i], 32'h300 + i);
    chk("t4_no_drop_end", drop_flag, 0);

    // ---- 5: per-word wrap and MSB boundary of the difficulty test ----
    do_reset();
    out_ready = 1'b1;
    load_nonce(32'h77);
    in_valid  = 1'b1;
    rx_state  = pack8(0, 0, 0, 32'hffffffff, 32'h12345678, 0, 0, 32'h7fffffff);
    mid_state = pack8(0, 0, 0, 32'h00000002, 32'h00000000, 0, 0, 32'h00000000);
    tick();
    mid_state = pack8(0, 0, 0, 0, 0, 0, 0, 32'h00000001);
    tick();
    idle(6);
    chk("t5_count", got_nonce.size(), 1);
    if (got_nonce.size() > 0) begin
      chk("t5_nonce",  got_nonce[0], 32'h77);
      chk("t5_digest", got_dig[0], pack8(0, 0, 0, 32'h00000001, 32'h12345678, 0, 0, 32'h7fffffff));
    end

    // ---- 6: reset mid-flight, then load coinciding with a beat ----
    do_reset();
    out_ready = 1'b0;
    mid_state = '0;
    load_nonce(32'h400);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      rx_state = pack8(32'h40 + i, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("t6_pre_ov", out_valid, 1);
    rst = 1'b1;
    tick();
    chk("t6_ov",    out_valid,  0);
    chk("t6_nonce", out_nonce,  0);
    chk("t6_dig",   out_digest, 0);
    chk("t6_hc",    hash_count, 0);
    chk("t6_drop",  drop_flag,  0);
    rst = 1'b0;
    got_nonce.delete();
    got_dig.delete();
    out_ready = 1'b1;
    idle(6);
    chk("t6_no_ghost", got_nonce.size(), 0);
    nonce_load  = 1'b1;
    nonce_start = 32'h500;
    in_valid    = 1'b1;
    rx_state    = pack8(32'h50, 0, 0, 0, 0, 0, 0, 0);
    tick();
    nonce_load  = 1'b0;
    rx_state    = pack8(32'h51, 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle(6);
    chk("t6_count", got_nonce.size(), 2);
    if (got_nonce.size() > 1) begin
      chk("t6_tag_load", got_nonce[0], 32'h500);
      chk("t6_tag_next", got_nonce[1], 32'h501);
    end
    chk("t6_hc_after", hash_count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
